// File: rtl/rvv_alu_seq.sv
// rtl/rvv_alu_seq.sv - element/beat sequencer for the lane-parallel vector ALU
//
// Takes one vector command through a start/busy handshake. It then steps
// byte_i (element group base) and in_reg_offset (sub-lane beat) so that every
// element 0..vl-1 is processed, one group of 2^nb_lanes elements at a time.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   start, *_in         command valid and fields; start is sampled only in IDLE
//   out_ready           downstream can accept the next element group
//   busy, done, err     handshake status; done and err are one-cycle pulses
//   run, wr_en          ALU enable and result-valid strobe (identical)
//   opcode, vsew, op_type, nb_lanes  latched command fields for the ALU
//   byte_i, in_reg_offset            current group base and sub-lane beat
//   lane_mask, last     per-lane element validity and final-beat flag
module rvv_alu_seq #(
  parameter int VLEN         = 128,
  parameter int LANE_WIDTH   = 3,
  parameter int MAX_NB_LANES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [5:0] opcode_in,
  input  logic [2:0] vsew_in,
  input  logic [2:0] op_type_in,
  input  logic [9:0] vl_in,
  input  logic [1:0] nb_lanes_in,
  input  logic       out_ready,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       run,
  output logic [5:0] opcode,
  output logic [2:0] vsew,
  output logic [2:0] op_type,
  output logic [1:0] nb_lanes,
  output logic [9:0] byte_i,
  output logic [3:0] in_reg_offset,
  output logic [3:0] lane_mask,
  output logic       wr_en,
  output logic       last
);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_BEAT, S_DONE, S_ERR} state_t;

  state_t      r_state;
  logic        r_busy, r_done, r_err, r_run;
  logic [5:0]  r_opcode;
  logic [2:0]  r_vsew, r_op_type;
  logic [1:0]  r_nb_lanes;
  logic [9:0]  r_vl, r_byte_i;
  logic [3:0]  r_offset;

  logic [31:0] w_vlmax_in;
  logic [9:0]  w_vl_clamped;
  logic        w_cmd_bad;
  logic [31:0] w_sew_bits;
  logic [3:0]  w_subs_m1;
  logic [10:0] w_lanes;
  logic [10:0] w_next_bi;
  logic        w_grp_end;
  logic        w_active;
  logic [3:0]  w_lane_mask;

  // Clamp the requested vl to VLMAX of the incoming SEW; a bad SEW goes to ERR,
  // so only the low two bits matter for the clamp.
  assign w_vlmax_in   = VLEN >> (32'(vsew_in[1:0]) + 32'd3);
  assign w_vl_clamped = ({22'd0, vl_in} > w_vlmax_in) ? w_vlmax_in[9:0] : vl_in;
  assign w_cmd_bad    = (vsew_in > 3'd3) || (32'(nb_lanes_in) > 32'(MAX_NB_LANES));

  // Beats per element: one if the element fits a lane, else 2^(sew_bits-lane_bits).
  assign w_sew_bits = 32'(r_vsew) + 32'd3;
  always_comb begin
    w_subs_m1 = 4'd0;
    if (w_sew_bits > 32'(LANE_WIDTH))
      w_subs_m1 = 4'((32'd1 << (w_sew_bits - 32'(LANE_WIDTH))) - 32'd1);
  end

  // 11-bit group arithmetic so byte_i + L never wraps near 1023.
  assign w_lanes   = 11'd1 << r_nb_lanes;
  assign w_next_bi = {1'b0, r_byte_i} + w_lanes;
  assign w_grp_end = (r_offset == w_subs_m1);
  assign w_active  = (r_state == S_WAIT) || (r_state == S_BEAT);

  always_comb begin
    w_lane_mask = 4'd0;
    for (int i = 0; i < 4; i++)
      w_lane_mask[i] = w_active && (11'(i) < w_lanes) &&
                       (({1'b0, r_byte_i} + 11'(i)) < {1'b0, r_vl});
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_run      <= 1'b0;
      r_opcode   <= 6'd0;
      r_vsew     <= 3'd0;
      r_op_type  <= 3'd0;
      r_nb_lanes <= 2'd0;
      r_vl       <= 10'd0;
      r_byte_i   <= 10'd0;
      r_offset   <= 4'd0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_busy <= 1'b0;
          r_run  <= 1'b0;
          if (start) begin
            r_opcode   <= opcode_in;
            r_vsew     <= vsew_in;
            r_op_type  <= op_type_in;
            r_nb_lanes <= nb_lanes_in;
            r_vl       <= w_vl_clamped;
            r_byte_i   <= 10'd0;
            r_offset   <= 4'd0;
            r_busy     <= 1'b1;
            if (w_cmd_bad) begin
              r_state <= S_ERR;
              r_err   <= 1'b1;
            end else if (w_vl_clamped == 10'd0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (out_ready) begin
            r_state <= S_BEAT;
            r_run   <= 1'b1;
          end
        end
        S_BEAT: begin
          // out_ready is not looked at here: a group's beats must stay contiguous.
          if (w_grp_end) begin
            r_offset <= 4'd0;
            r_byte_i <= w_next_bi[9:0];
            r_run    <= 1'b0;
            if (w_next_bi >= {1'b0, r_vl}) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_WAIT;
            end
          end else begin
            r_offset <= r_offset + 4'd1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        S_ERR: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_run   <= 1'b0;
        end
      endcase
    end
  end

  assign busy          = r_busy;
  assign done          = r_done;
  assign err           = r_err;
  assign run           = r_run;
  assign wr_en         = r_run;
  assign opcode        = r_opcode;
  assign vsew          = r_vsew;
  assign op_type       = r_op_type;
  assign nb_lanes      = r_nb_lanes;
  assign byte_i        = r_byte_i;
  assign in_reg_offset = r_offset;
  assign lane_mask     = w_lane_mask;
  assign last          = (r_state == S_BEAT) && w_grp_end && (w_next_bi >= {1'b0, r_vl});

endmodule

// File: tb/tb_rvv_alu_seq.sv
// tb/tb_rvv_alu_seq.sv - self-checking bench for rvv_alu_seq
module tb_rvv_alu_seq;

  localparam int VLEN = 128;
  localparam int LW   = 3;

  logic       clk = 1'b0;
  logic       reset, start, out_ready;
  logic [5:0] opcode_in;
  logic [2:0] vsew_in, op_type_in;
  logic [9:0] vl_in;
  logic [1:0] nb_lanes_in;
  logic       busy, done, err, run, wr_en, last;
  logic [5:0] opcode;
  logic [2:0] vsew, op_type;
  logic [1:0] nb_lanes;
  logic [9:0] byte_i;
  logic [3:0] in_reg_offset, lane_mask;

  always #5 clk = ~clk;

  rvv_alu_seq #(.VLEN(VLEN), .LANE_WIDTH(LW), .MAX_NB_LANES(2)) dut (
    .clk(clk), .reset(reset), .start(start), .opcode_in(opcode_in),
    .vsew_in(vsew_in), .op_type_in(op_type_in), .vl_in(vl_in),
    .nb_lanes_in(nb_lanes_in), .out_ready(out_ready), .busy(busy),
    .done(done), .err(err), .run(run), .opcode(opcode), .vsew(vsew),
    .op_type(op_type), .nb_lanes(nb_lanes), .byte_i(byte_i),
    .in_reg_offset(in_reg_offset), .lane_mask(lane_mask), .wr_en(wr_en),
    .last(last)
  );

  typedef struct {
    logic [2:0] sew;
    logic [1:0] nb;
    logic [9:0] vl;
    logic [5:0] opc;
    int         exp_end;
    bit         exp_err;
  } vec_t;

  typedef struct {
    int cyc;
    int bi;
    int off;
    int mask;
    bit lst;
  } beat_t;

  beat_t got_q[$];
  beat_t exp_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  vec_t  tbl[9];

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int pk(input beat_t b);
    return (b.bi << 12) | (b.off << 8) | (b.mask << 4) | int'(b.lst);
  endfunction

  // Expected beat list straight from the element/group rules.
  function automatic void build_model(input int sew, input int nb, input int vl);
    int    vlc, subs, lanes;
    beat_t e;
    exp_q.delete();
    if (sew > 3 || nb > 2) return;
    vlc   = (vl > (VLEN >> (sew + 3))) ? (VLEN >> (sew + 3)) : vl;
    subs  = (sew + 3 <= LW) ? 1 : (1 << (sew + 3 - LW));
    lanes = 1 << nb;
    for (int b = 0; b < vlc; b += lanes) begin
      for (int s = 0; s < subs; s++) begin
        e.cyc  = 0;
        e.bi   = b;
        e.off  = s;
        e.mask = 0;
        for (int i = 0; i < lanes; i++)
          if (b + i < vlc) e.mask |= (1 << i);
        e.lst = (s == subs - 1) && (b + lanes >= vlc);
        exp_q.push_back(e);
      end
    end
  endfunction

  // Issue one command and follow it to done/err. Cycle 0 is the start cycle.
  task automatic run_cmd(input logic [5:0] opc, input logic [2:0] sew,
                         input logic [1:0] nb, input logic [9:0] vl,
                         input logic [63:0] pat, input bit rnd,
                         input int restart_at, input int exp_end, input bit exp_err);
    int    c, end_c, n_done, n_err, n_idle, n_wr_bad, n_opc_bad, nmin;
    bit    fin;
    beat_t b;
    build_model(int'(sew), int'(nb), int'(vl));
    got_q.delete();
    n_done = 0; n_err = 0; n_idle = 0; n_wr_bad = 0; n_opc_bad = 0;
    opcode_in   = opc;
    vsew_in     = sew;
    op_type_in  = 3'b001;
    vl_in       = vl;
    nb_lanes_in = nb;
    start       = 1'b1;
    out_ready   = rnd ? 1'($urandom_range(0, 1)) : pat[0];
    @(posedge clk); #1;
    start = 1'b0;
    c = 1; fin = 1'b0; end_c = -1;
    while (!fin && c < 2000) begin
      if (c == restart_at) begin
        start     = 1'b1;
        opcode_in = opc ^ 6'h3f;
        vl_in     = 10'd9;
      end else begin
        start = 1'b0;
      end
      out_ready = rnd ? 1'($urandom_range(0, 1)) : ((c < 64) ? pat[c] : 1'b1);
      @(negedge clk);
      if (run) begin
        b.cyc  = c;
        b.bi   = int'(byte_i);
        b.off  = int'(in_reg_offset);
        b.mask = int'(lane_mask);
        b.lst  = last;
        got_q.push_back(b);
        if (opcode != opc) n_opc_bad++;
      end
      if (wr_en !== run) n_wr_bad++;
      if (!busy) n_idle++;
      if (done) n_done++;
      if (err) n_err++;
      if (done || err) begin
        fin   = 1'b1;
        end_c = c;
      end
      @(posedge clk); #1;
      c++;
    end
    start = 1'b0;
    chk("finished", int'(fin), 1);
    chk("nbeats", got_q.size(), exp_q.size());
    nmin = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int k = 0; k < nmin; k++) begin
      chk($sformatf("beat%0d", k), pk(got_q[k]), pk(exp_q[k]));
      if (k > 0 && exp_q[k].bi == exp_q[k-1].bi)
        chk($sformatf("contig%0d", k), got_q[k].cyc - got_q[k-1].cyc, 1);
    end
    chk("opcode_latched", n_opc_bad, 0);
    chk("wr_en_eq_run", n_wr_bad, 0);
    chk("busy_held", n_idle, 0);
    chk("done_pulse", n_done, exp_err ? 0 : 1);
    chk("err_pulse", n_err, exp_err ? 1 : 0);
    if (exp_end >= 0) chk("end_cycle", end_c, exp_end);
  endtask

  initial begin
    tbl[0] = '{3'd2, 2'd1, 10'd3,    6'h01, 11, 1'b0};
    tbl[1] = '{3'd0, 2'd2, 10'd5,    6'h02, 5,  1'b0};
    tbl[2] = '{3'd0, 2'd0, 10'd0,    6'h03, 1,  1'b0};
    tbl[3] = '{3'd5, 2'd0, 10'd4,    6'h04, 1,  1'b1};
    tbl[4] = '{3'd2, 2'd0, 10'd100,  6'h05, 21, 1'b0};
    tbl[5] = '{3'd3, 2'd0, 10'd2,    6'h06, 19, 1'b0};
    tbl[6] = '{3'd1, 2'd2, 10'd16,   6'h07, 7,  1'b0};
    tbl[7] = '{3'd0, 2'd3, 10'd4,    6'h08, 1,  1'b1};
    tbl[8] = '{3'd0, 2'd2, 10'd1023, 6'h09, 9,  1'b0};

    reset = 1'b1; start = 1'b0; out_ready = 1'b0;
    opcode_in = 6'd0; vsew_in = 3'd0; op_type_in = 3'd0; vl_in = 10'd0; nb_lanes_in = 2'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_run", int'(run), 0);
    chk("rst_done_err", int'({done, err}), 0);
    chk("rst_fields", int'({opcode, vsew, op_type, nb_lanes}), 0);
    chk("rst_counters", int'({byte_i, in_reg_offset, lane_mask, last}), 0);
    @(posedge clk); #1;
    reset = 1'b0;

    for (int t = 0; t < 9; t++)
      run_cmd(tbl[t].opc, tbl[t].sew, tbl[t].nb, tbl[t].vl, '1, 1'b0, -1,
              tbl[t].exp_end, tbl[t].exp_err);

    // Stall between groups plus a mid-group ready drop that must be ignored.
    run_cmd(6'h10, 3'd3, 2'd0, 10'd2, ~64'h1C30, 1'b0, -1, 22, 1'b0);
    if (got_q.size() >= 9) begin
      chk("stall_grp0_end", got_q[7].cyc, 9);
      chk("stall_grp1_start", got_q[8].cyc, 14);
    end else begin
      chk("stall_beats", got_q.size(), 16);
    end

    // Start while busy must be ignored and not queued.
    run_cmd(6'h11, 3'd0, 2'd0, 10'd3, '1, 1'b0, 2, 7, 1'b0);
    @(negedge clk);
    chk("no_queue_busy0", int'(busy), 0);
    @(negedge clk);
    chk("no_queue_busy1", int'(busy), 0);
    @(posedge clk); #1;

    // Reset in the middle of the third beat.
    begin
      int runs;
      opcode_in = 6'h12; vsew_in = 3'd0; nb_lanes_in = 2'd0; vl_in = 10'd8;
      out_ready = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      runs = 0;
      for (int k = 0; k < 50 && runs < 3; k++) begin
        @(negedge clk);
        if (run) runs++;
      end
      chk("rst_mid_reach", runs, 3);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      chk("rstmid_run", int'(run), 0);
      chk("rstmid_busy", int'(busy), 0);
      chk("rstmid_counters", int'({byte_i, in_reg_offset}), 0);
      chk("rstmid_done", int'(done), 0);
      @(posedge clk); #1;
      run_cmd(6'h13, 3'd0, 2'd1, 10'd2, '1, 1'b0, -1, 3, 1'b0);
    end

    // Randomized commands and ready patterns against the beat model.
    for (int r = 0; r < 25; r++) begin
      logic [2:0] s;
      logic [1:0] n;
      s = 3'($urandom_range(0, 4));
      n = 2'($urandom_range(0, 3));
      run_cmd(6'($urandom), s, n, 10'($urandom_range(0, 40)), '0, 1'b1, -1, -1,
              (s > 3'd3) || (n > 2'd2));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
